updown_counter_4bit: RTL and testbench



---
 rtl/updown_counter_4bit.sv | 28 ++
 tb/tb_updown_counter_4bit.sv | 118 +++++++++++
 2 files changed

// File: rtl/updown_counter_4bit.sv
// 4-bit synchronous up/down counter, wraps modulo 2^WIDTH.
// Count direction is chosen by ctrl; rst_n is an active-high synchronous clear.
module updown_counter_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ctrl,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_step;

  // +1 or -1 in two's complement; the adder width supplies the wrap
  assign w_step = ctrl ? WIDTH'(1) : {WIDTH{1'b1}};

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + w_step;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: tb/tb_updown_counter_4bit.sv
// Scoreboard bench for updown_counter_4bit: driver pushes model values,
// a negedge monitor pops and compares against cnt.
module tb_updown_counter_4bit;

  logic       clk;
  logic       rst_n;
  logic       ctrl;
  logic [3:0] cnt;

  typedef struct {
    int    exp;
    string tag;
  } exp_t;

  exp_t q[$];
  int   vectors;
  int   miscompares;
  int   ref_cnt;
  bit   ref_known;

  updown_counter_4bit #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ctrl (ctrl),
    .cnt  (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge of stimulus; model result is queued after the edge.
  task automatic step(input bit r, input bit c, input string tag);
    exp_t e;
    @(negedge clk);
    rst_n = r;
    ctrl  = c;
    @(posedge clk);
    if (r) begin
      ref_cnt   = 0;
      ref_known = 1'b1;
    end else if (ref_known) begin
      ref_cnt = (((ref_cnt + (c ? 1 : -1)) % 16) + 16) % 16;
    end
    if (ref_known) begin
      e.exp = ref_cnt;
      e.tag = tag;
      q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if (int'(cnt) != e.exp) begin
        miscompares++;
        $display("FAIL %s: cnt=%0d expected=%0d at %0t",
                 e.tag, cnt, e.exp, $time);
      end
    end
  end

  initial begin
    int wait_cycles;
    vectors     = 0;
    miscompares = 0;
    ref_cnt     = 0;
    ref_known   = 1'b0;
    rst_n       = 1'b1;
    ctrl        = 1'b1;

    // reset hold then release upward
    step(1, 1, "reset0");
    step(1, 1, "reset1");
    for (int i = 0; i < 3; i++) step(0, 1, "rel_up");

    // up wrap: 15 -> 0 -> 1
    step(1, 1, "rst_upwrap");
    for (int i = 0; i < 17; i++) step(0, 1, "up_wrap");

    // down wrap: 0 -> 15 -> 14 -> 13
    step(1, 0, "rst_dnwrap");
    for (int i = 0; i < 3; i++) step(0, 0, "down_wrap");

    // direction change: up to 5, down 2, up 1
    step(1, 1, "rst_dir");
    for (int i = 0; i < 5; i++) step(0, 1, "dir_up");
    for (int i = 0; i < 2; i++) step(0, 0, "dir_down");
    step(0, 1, "dir_back_up");

    // reset mid-count at 9 while counting down
    step(1, 0, "rst_mid0");
    for (int i = 0; i < 7; i++) step(0, 0, "to_nine");
    step(1, 0, "rst_mid");
    step(0, 0, "after_rst");

    // random direction with sparse reset pulses
    for (int i = 0; i < 1000; i++) begin
      step(($urandom_range(0, 19) == 0), 1'($urandom), "random");
    end

    wait_cycles = 0;
    while (q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: pending=%0d expected=0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
